eth_frame_parser: RTL and testbench



---
 rtl/eth_pkg.sv | 56 +++++
 rtl/eth_frame_parser_if.sv | 13 +
 rtl/eth_field_match.sv | 51 +++++
 rtl/eth_frame_parser.sv | 172 +++++++++++++++++
 tb/tb_eth_frame_parser.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared constants, word map and FSM encoding for the rx frame parser.
// Pure declarations: no latency, no flow control.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ   = 16'd1;
    localparam logic [15:0] ARP_OP_RESP  = 16'd2;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;

    // Word indices in the shift-16 aligned 32-bit stream
    localparam logic [3:0] W_DST_HI     = 4'd0;
    localparam logic [3:0] W_DST_LO     = 4'd1;
    localparam logic [3:0] W_TYPE       = 4'd3;
    localparam logic [3:0] W_IP_VER     = 4'd4;
    localparam logic [3:0] W_ARP_OP     = 4'd5;
    localparam logic [3:0] W_ARP_SHA    = 4'd6;
    localparam logic [3:0] W_IP_PROTO   = 4'd6;
    localparam logic [3:0] W_ARP_SPA_HI = 4'd7;
    localparam logic [3:0] W_ARP_SPA_LO = 4'd8;
    localparam logic [3:0] W_IP_DST     = 4'd8;
    localparam logic [3:0] W_UDP_PORT   = 4'd9;
    localparam logic [3:0] W_ARP_TPA    = 4'd10;
    localparam logic [3:0] W_IP_LAST    = 4'd10;
    localparam logic [3:0] W_CMD_HDR    = 4'd11;
    localparam logic [3:0] W_CMD_DATA   = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_ARP,
        ST_IP,
        ST_PAYLOAD,
        ST_TAIL,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic dst_self;
        logic dst_bcast;
        logic type_arp;
        logic type_ip;
        logic oper_req;
        logic oper_resp;
        logic spa_hi;
        logic spa_lo;
        logic tpa;
        logic ver;
        logic proto;
        logic dip;
        logic port;
        logic magic;
    } match_t;

endpackage

// File: rtl/eth_frame_parser_if.sv
// Avalon-ST style rx word stream between the TSE pump and the frame parser.
// Wires only; the sink side drives o_rdy.
interface eth_frame_parser_if;
    logic [31:0] i_data;
    logic        i_vld;
    logic        o_rdy;
    logic        i_sop;
    logic        i_eop;
    logic        i_err;

    modport master (output i_data, i_vld, i_sop, i_eop, i_err, input o_rdy);
    modport slave  (input i_data, i_vld, i_sop, i_eop, i_err, output o_rdy);
endinterface

// File: rtl/eth_field_match.sv
// Per-word field comparators; each flag is true only on the word index that carries its field.
// Purely combinational, no flow control.
module eth_field_match
    import eth_pkg::*;
#(
    parameter logic [15:0] CMD_PORT  = 16'd50000,
    parameter logic [15:0] CMD_MAGIC = 16'hC0DE
) (
    input  logic [3:0]  idx,
    input  logic [31:0] data,
    input  logic [47:0] self_mac,
    input  logic [31:0] self_ip,
    input  logic [31:0] target_ip,
    output match_t      m
);

    always_comb begin
        m = '0;
        case (idx)
            W_DST_HI: begin
                m.dst_self  = (data[15:0] == self_mac[47:32]);
                m.dst_bcast = (data[15:0] == 16'hFFFF);
            end
            W_DST_LO: begin
                m.dst_self  = (data == self_mac[31:0]);
                m.dst_bcast = (data == 32'hFFFF_FFFF);
            end
            W_TYPE: begin
                m.type_arp = (data[15:0] == ETH_TYPE_ARP);
                m.type_ip  = (data[15:0] == ETH_TYPE_IP);
            end
            W_IP_VER: m.ver = (data[31:24] == IP_VER_IHL);
            W_ARP_OP: begin
                m.oper_req  = (data[15:0] == ARP_OP_REQ);
                m.oper_resp = (data[15:0] == ARP_OP_RESP);
            end
            W_IP_PROTO:   m.proto  = (data[23:16] == IP_PROTO_UDP);
            W_ARP_SPA_HI: m.spa_hi = (data[15:0] == target_ip[31:16]);
            W_ARP_SPA_LO: begin
                // ARP spa low half and IPv4 destination share this word
                m.spa_lo = (data[31:16] == target_ip[15:0]);
                m.dip    = (data == self_ip);
            end
            W_UDP_PORT: m.port  = (data[15:0] == CMD_PORT);
            W_ARP_TPA:  m.tpa   = (data == self_ip);
            W_CMD_HDR:  m.magic = (data[31:16] == CMD_MAGIC);
            default: ;
        endcase
    end

endmodule

// File: rtl/eth_frame_parser.sv
// Filters rx frames by MAC/IP and decodes ARP and UDP command datagrams into result pulses.
// Results pulse one cycle after the eop beat; o_rdy is high outside reset, never backpressures.
module eth_frame_parser
    import eth_pkg::*;
#(
    parameter logic [15:0] CMD_PORT  = 16'd50000,
    parameter logic [15:0] CMD_MAGIC = 16'hC0DE,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          i_self_mac,
    input  logic [31:0]          i_self_ip,
    input  logic [31:0]          i_target_ip,
    eth_frame_parser_if.slave    rx,
    output logic [1:0]           o_arp_operation,
    output logic [47:0]          o_arp_sender_mac,
    output logic [31:0]          o_arp_sender_ip,
    output logic                 o_cmd_flag,
    output logic [1:0]           o_cmd_phy_channel,
    output logic [31:0]          o_cmd_data,
    output logic [CNT_W-1:0]     o_frame_cnt,
    output logic [CNT_W-1:0]     o_drop_cnt
);

    state_t      state, st_eff, st_nxt;
    logic [3:0]  idx, cur_idx;
    match_t      m;
    logic        dsth_self, dsth_bcast, op_resp_r, spa_hi_r, spa_lo_r, is_arp_r;
    logic [47:0] sha_sh;
    logic [31:0] spa_sh, data_sh;
    logic [1:0]  ch_sh;
    logic        beat, done_arp, done_cmd, complete, arp_res, accept, abort, eop_drop;
    logic [1:0]  drop_inc;

    assign rx.o_rdy = ~rst;
    assign beat     = rx.i_vld && rx.o_rdy;
    // An sop beat always restarts parsing at W0, whatever state we were in
    assign cur_idx  = rx.i_sop ? 4'd0 : idx;
    assign st_eff   = rx.i_sop ? ST_MAC : state;

    eth_field_match #(.CMD_PORT(CMD_PORT), .CMD_MAGIC(CMD_MAGIC)) u_match (
        .idx       (cur_idx),
        .data      (rx.i_data),
        .self_mac  (i_self_mac),
        .self_ip   (i_self_ip),
        .target_ip (i_target_ip),
        .m         (m)
    );

    always_comb begin
        st_nxt   = st_eff;
        done_arp = 1'b0;
        done_cmd = 1'b0;
        case (st_eff)
            ST_MAC: case (cur_idx)
                W_DST_HI: if (!(m.dst_self || m.dst_bcast)) st_nxt = ST_DROP;
                W_DST_LO: if (!((dsth_self && m.dst_self) || (dsth_bcast && m.dst_bcast)))
                              st_nxt = ST_DROP;
                W_TYPE:   st_nxt = m.type_arp ? ST_ARP : (m.type_ip ? ST_IP : ST_DROP);
                default: ;
            endcase
            ST_ARP: case (cur_idx)
                W_ARP_OP: if (!(m.oper_req || m.oper_resp)) st_nxt = ST_DROP;
                W_ARP_TPA: begin
                    if (m.tpa && (!op_resp_r || (spa_hi_r && spa_lo_r))) begin
                        done_arp = 1'b1;
                        st_nxt   = ST_TAIL;
                    end else begin
                        st_nxt = ST_DROP;
                    end
                end
                default: ;
            endcase
            ST_IP: case (cur_idx)
                W_IP_VER:   if (!m.ver)   st_nxt = ST_DROP;
                W_IP_PROTO: if (!m.proto) st_nxt = ST_DROP;
                W_IP_DST:   if (!m.dip)   st_nxt = ST_DROP;
                W_UDP_PORT: if (!m.port)  st_nxt = ST_DROP;
                W_IP_LAST:  st_nxt = ST_PAYLOAD;
                default: ;
            endcase
            ST_PAYLOAD: case (cur_idx)
                W_CMD_HDR: if (!m.magic) st_nxt = ST_DROP;
                W_CMD_DATA: begin
                    done_cmd = 1'b1;
                    st_nxt   = ST_TAIL;
                end
                default: ;
            endcase
            default: ;
        endcase
    end

    assign complete = done_arp || done_cmd || (st_eff == ST_TAIL);
    assign arp_res  = done_arp || ((st_eff == ST_TAIL) && is_arp_r);
    assign accept   = rx.i_eop && complete && !rx.i_err;
    assign abort    = rx.i_sop && (state != ST_IDLE);
    assign eop_drop = rx.i_eop && !accept;
    assign drop_inc = {1'b0, abort} + {1'b0, eop_drop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            idx               <= '0;
            dsth_self         <= 1'b0;
            dsth_bcast        <= 1'b0;
            op_resp_r         <= 1'b0;
            spa_hi_r          <= 1'b0;
            spa_lo_r          <= 1'b0;
            is_arp_r          <= 1'b0;
            sha_sh            <= '0;
            spa_sh            <= '0;
            ch_sh             <= '0;
            data_sh           <= '0;
            o_arp_operation   <= '0;
            o_arp_sender_mac  <= '0;
            o_arp_sender_ip   <= '0;
            o_cmd_flag        <= 1'b0;
            o_cmd_phy_channel <= '0;
            o_cmd_data        <= '0;
            o_frame_cnt       <= '0;
            o_drop_cnt        <= '0;
        end else begin
            o_arp_operation <= '0;
            o_cmd_flag      <= 1'b0;
            if (beat && (st_eff != ST_IDLE)) begin
                idx <= (cur_idx == 4'hF) ? 4'hF : cur_idx + 4'd1;
                if (st_eff == ST_MAC && cur_idx == W_DST_HI) begin
                    dsth_self  <= m.dst_self;
                    dsth_bcast <= m.dst_bcast;
                end
                if (st_eff == ST_ARP) begin
                    case (cur_idx)
                        W_ARP_OP:  op_resp_r <= m.oper_resp;
                        W_ARP_SHA: sha_sh[47:16] <= rx.i_data;
                        W_ARP_SPA_HI: begin
                            sha_sh[15:0]  <= rx.i_data[31:16];
                            spa_sh[31:16] <= rx.i_data[15:0];
                            spa_hi_r      <= m.spa_hi;
                        end
                        W_ARP_SPA_LO: begin
                            spa_sh[15:0] <= rx.i_data[31:16];
                            spa_lo_r     <= m.spa_lo;
                        end
                        default: ;
                    endcase
                end
                if (st_eff == ST_PAYLOAD && cur_idx == W_CMD_HDR)  ch_sh   <= rx.i_data[1:0];
                if (st_eff == ST_PAYLOAD && cur_idx == W_CMD_DATA) data_sh <= rx.i_data;
                if (done_arp) is_arp_r <= 1'b1;
                if (done_cmd) is_arp_r <= 1'b0;

                state      <= rx.i_eop ? ST_IDLE : st_nxt;
                o_drop_cnt <= o_drop_cnt + CNT_W'(drop_inc);
                if (accept) begin
                    o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                    if (arp_res) begin
                        o_arp_operation  <= op_resp_r ? 2'd2 : 2'd1;
                        o_arp_sender_mac <= sha_sh;
                        o_arp_sender_ip  <= spa_sh;
                    end else begin
                        o_cmd_flag        <= 1'b1;
                        o_cmd_phy_channel <= ch_sh;
                        o_cmd_data        <= done_cmd ? rx.i_data : data_sh;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_parser.sv
// Scoreboard bench for eth_frame_parser: expected pulses are queued at the eop beat and popped by a monitor.
// Counters and held outputs are compared against a bench-side model after each scenario.
module tb_eth_frame_parser;
    import eth_pkg::*;

    localparam logic [47:0] SELF_MAC  = 48'h0200_0000_000B;
    localparam logic [31:0] SELF_IP   = 32'hC0A8_010B;
    localparam logic [31:0] TARGET_IP = 32'hC0A8_01B5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_frame_parser_if rx();

    logic [1:0]  o_arp_operation;
    logic [47:0] o_arp_sender_mac;
    logic [31:0] o_arp_sender_ip;
    logic        o_cmd_flag;
    logic [1:0]  o_cmd_phy_channel;
    logic [31:0] o_cmd_data;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_drop_cnt;

    eth_frame_parser dut (
        .clk               (clk),
        .rst               (rst),
        .i_self_mac        (SELF_MAC),
        .i_self_ip         (SELF_IP),
        .i_target_ip       (TARGET_IP),
        .rx                (rx),
        .o_arp_operation   (o_arp_operation),
        .o_arp_sender_mac  (o_arp_sender_mac),
        .o_arp_sender_ip   (o_arp_sender_ip),
        .o_cmd_flag        (o_cmd_flag),
        .o_cmd_phy_channel (o_cmd_phy_channel),
        .o_cmd_data        (o_cmd_data),
        .o_frame_cnt       (o_frame_cnt),
        .o_drop_cnt        (o_drop_cnt)
    );

    typedef struct {
        bit          is_arp;
        logic [1:0]  op;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [1:0]  ch;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_frames = 0;
    int          exp_drops  = 0;
    logic [47:0] held_mac  = '0;
    logic [31:0] held_ip   = '0;
    logic [1:0]  held_ch   = '0;
    logic [31:0] held_data = '0;
    logic [31:0] frm [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    // Every result pulse must match the head of the scoreboard, including its cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (o_arp_operation != 2'd0 || o_cmd_flag)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: arp_op=%0d cmd_flag=%0b at cycle %0d, required no pulse",
                         o_arp_operation, o_cmd_flag, cyc);
            end else begin
                e = sb.pop_front();
                if (e.is_arp) begin
                    if (o_arp_operation !== e.op || o_cmd_flag !== 1'b0 || o_arp_sender_mac !== e.mac ||
                        o_arp_sender_ip !== e.ip || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL arp_result: op=%0d cmd=%0b mac=%h ip=%h cyc=%0d, required op=%0d cmd=0 mac=%h ip=%h cyc=%0d",
                                 o_arp_operation, o_cmd_flag, o_arp_sender_mac, o_arp_sender_ip, cyc,
                                 e.op, e.mac, e.ip, e.cyc);
                    end
                end else begin
                    if (o_cmd_flag !== 1'b1 || o_arp_operation !== 2'd0 || o_cmd_phy_channel !== e.ch ||
                        o_cmd_data !== e.data || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL cmd_result: flag=%0b arp=%0d ch=%0d data=%h cyc=%0d, required flag=1 arp=0 ch=%0d data=%h cyc=%0d",
                                 o_cmd_flag, o_arp_operation, o_cmd_phy_channel, o_cmd_data, cyc,
                                 e.ch, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic build_arp(input logic [47:0] dst, input logic [15:0] oper, input logic [47:0] sha,
                             input logic [31:0] spa, input logic [31:0] tpa);
        for (int i = 0; i < 16; i++) frm[i] = 32'h0;
        frm[0]  = {16'h0, dst[47:32]};
        frm[1]  = dst[31:0];
        frm[2]  = sha[47:16];
        frm[3]  = {sha[15:0], ETH_TYPE_ARP};
        frm[4]  = 32'h0001_0800;
        frm[5]  = {16'h0604, oper};
        frm[6]  = sha[47:16];
        frm[7]  = {sha[15:0], spa[31:16]};
        frm[8]  = {spa[15:0], 16'h0};
        frm[10] = tpa;
        pend.is_arp = 1'b1;
        pend.op     = oper[1:0];
        pend.mac    = sha;
        pend.ip     = spa;
    endtask

    task automatic build_udp(input logic [47:0] dst, input logic [15:0] port,
                             input logic [31:0] w11, input logic [31:0] w12);
        for (int i = 0; i < 16; i++) frm[i] = 32'h0;
        frm[0]  = {16'h0, dst[47:32]};
        frm[1]  = dst[31:0];
        frm[2]  = 32'h0011_2233;
        frm[3]  = {16'h4455, ETH_TYPE_IP};
        frm[4]  = 32'h4500_0024;
        frm[6]  = 32'h4011_0000;
        frm[7]  = TARGET_IP;
        frm[8]  = SELF_IP;
        frm[9]  = {16'd4000, port};
        frm[11] = w11;
        frm[12] = w12;
        pend.is_arp = 1'b0;
        pend.ch     = w11[1:0];
        pend.data   = w12;
    endtask

    // Drives frm[first..last]; when good, queues the expected pulse for the cycle after eop
    task automatic send_words(input int first, input int last, input bit sop, input bit eop,
                              input bit err, input int gap_max, input bit good);
        for (int i = first; i <= last; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                rx.i_vld = 1'b0;
            end
            @(negedge clk);
            rx.i_vld  = 1'b1;
            rx.i_data = frm[i];
            rx.i_sop  = sop && (i == first);
            rx.i_eop  = eop && (i == last);
            rx.i_err  = err && (i == last);
            if (eop && good && i == last) begin
                pend.cyc = cyc + 1;
                sb.push_back(pend);
                if (pend.is_arp) begin
                    held_mac = pend.mac;
                    held_ip  = pend.ip;
                end else begin
                    held_ch   = pend.ch;
                    held_data = pend.data;
                end
            end
        end
        @(negedge clk);
        rx.i_vld = 1'b0;
        rx.i_sop = 1'b0;
        rx.i_eop = 1'b0;
        rx.i_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx.o_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b, required 0", rx.o_rdy); end
        n_checks++;
        if ({o_arp_operation, o_arp_sender_mac, o_arp_sender_ip, o_cmd_flag, o_cmd_phy_channel, o_cmd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: arp=%0d mac=%h ip=%h cmd=%0b ch=%0d data=%h, required all 0",
                     o_arp_operation, o_arp_sender_mac, o_arp_sender_ip, o_cmd_flag, o_cmd_phy_channel, o_cmd_data);
        end
        n_checks++;
        if (o_frame_cnt !== 16'd0 || o_drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters: frame=%0d drop=%0d, required 0 0", o_frame_cnt, o_drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rx.o_rdy !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, required 1", rx.o_rdy); end
    endtask

    task automatic test_arp;
        build_arp(48'hFFFF_FFFF_FFFF, ARP_OP_REQ, 48'h0011_2233_4455, TARGET_IP, SELF_IP);
        send_words(0, 15, 1, 1, 0, 0, 1);
        exp_frames++;
        build_arp(SELF_MAC, ARP_OP_RESP, 48'h0A0B_0C0D_0E0F, TARGET_IP, SELF_IP);
        send_words(0, 15, 1, 1, 0, 0, 1);
        exp_frames++;
        build_arp(SELF_MAC, ARP_OP_RESP, 48'h0A0B_0C0D_0E10, 32'hC0A8_0163, SELF_IP);
        send_words(0, 15, 1, 1, 0, 0, 0);
        exp_drops++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL arp_pending: %0d pulses missing, required 0", sb.size()); end
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames) || o_drop_cnt !== 16'(exp_drops)) begin
            n_fail++; $display("FAIL arp_counters: frame=%0d drop=%0d, required %0d %0d", o_frame_cnt, o_drop_cnt, exp_frames, exp_drops);
        end
        n_checks++;
        if (o_arp_sender_mac !== held_mac || o_arp_sender_ip !== held_ip) begin
            n_fail++; $display("FAIL arp_held: mac=%h ip=%h, required %h %h", o_arp_sender_mac, o_arp_sender_ip, held_mac, held_ip);
        end
    endtask

    task automatic test_udp_cmd;
        build_udp(SELF_MAC, 16'd50000, 32'hC0DE_0002, 32'h1234_5678);
        send_words(0, 13, 1, 1, 0, 0, 1);
        exp_frames++;
        build_udp(SELF_MAC, 16'd50001, 32'hC0DE_0001, 32'h5555_0000);
        send_words(0, 13, 1, 1, 0, 0, 0);
        exp_drops++;
        build_udp(48'h0200_0000_000C, 16'd50000, 32'hC0DE_0003, 32'h6666_0000);
        send_words(0, 13, 1, 1, 0, 0, 0);
        exp_drops++;
        build_udp(SELF_MAC, 16'd50000, 32'hBEEF_0001, 32'h7777_0000);
        send_words(0, 13, 1, 1, 0, 0, 0);
        exp_drops++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL cmd_pending: %0d pulses missing, required 0", sb.size()); end
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames) || o_drop_cnt !== 16'(exp_drops)) begin
            n_fail++; $display("FAIL cmd_counters: frame=%0d drop=%0d, required %0d %0d", o_frame_cnt, o_drop_cnt, exp_frames, exp_drops);
        end
        n_checks++;
        if (o_cmd_phy_channel !== 2'd2 || o_cmd_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL cmd_held: ch=%0d data=%h, required 2 12345678", o_cmd_phy_channel, o_cmd_data);
        end
    endtask

    task automatic test_short_err;
        build_udp(SELF_MAC, 16'd50000, 32'hC0DE_0001, 32'hDEAD_BEEF);
        send_words(0, 9, 1, 1, 0, 0, 0);
        send_words(0, 13, 1, 1, 1, 0, 0);
        exp_drops += 2;
        build_arp(SELF_MAC, ARP_OP_REQ, 48'h0099_8877_6655, 32'hC0A8_0177, SELF_IP);
        send_words(0, 15, 1, 1, 1, 0, 0);
        exp_drops++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames) || o_drop_cnt !== 16'(exp_drops)) begin
            n_fail++; $display("FAIL short_err_counters: frame=%0d drop=%0d, required %0d %0d", o_frame_cnt, o_drop_cnt, exp_frames, exp_drops);
        end
        n_checks++;
        if (o_cmd_phy_channel !== held_ch || o_cmd_data !== held_data ||
            o_arp_sender_mac !== held_mac || o_arp_sender_ip !== held_ip) begin
            n_fail++; $display("FAIL short_err_held: ch=%0d data=%h mac=%h ip=%h, required %0d %h %h %h",
                               o_cmd_phy_channel, o_cmd_data, o_arp_sender_mac, o_arp_sender_ip,
                               held_ch, held_data, held_mac, held_ip);
        end
    endtask

    task automatic test_back_to_back;
        build_udp(SELF_MAC, 16'd50000, 32'hC0DE_0001, 32'hAAAA_5555);
        send_words(0, 5, 1, 0, 0, 0, 0);
        exp_drops++;
        build_udp(SELF_MAC, 16'd50000, 32'hC0DE_0003, 32'h0BAD_F00D);
        send_words(0, 13, 1, 1, 0, 0, 1);
        exp_frames++;
        for (int r = 0; r < 3; r++) begin
            build_arp(48'hFFFF_FFFF_FFFF, ARP_OP_REQ, 48'h0011_2233_4400 + 48'(r), TARGET_IP, SELF_IP);
            send_words(0, 15, 1, 1, 0, 3, 1);
            build_udp(SELF_MAC, 16'd50000, 32'hC0DE_0000 + 32'(r), 32'h1234_0000 + 32'(r));
            send_words(0, 13, 1, 1, 0, 3, 1);
            exp_frames += 2;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_pending: %0d pulses missing, required 0", sb.size()); end
        n_checks++;
        if (o_frame_cnt !== 16'(exp_frames) || o_drop_cnt !== 16'(exp_drops)) begin
            n_fail++; $display("FAIL b2b_counters: frame=%0d drop=%0d, required %0d %0d", o_frame_cnt, o_drop_cnt, exp_frames, exp_drops);
        end
        n_checks++;
        if (o_cmd_data !== held_data || o_arp_sender_mac !== held_mac) begin
            n_fail++; $display("FAIL b2b_held: data=%h mac=%h, required %h %h", o_cmd_data, o_arp_sender_mac, held_data, held_mac);
        end
    endtask

    task automatic test_reset_mid;
        build_udp(SELF_MAC, 16'd50000, 32'hC0DE_0001, 32'hCAFE_0001);
        send_words(0, 6, 1, 0, 0, 0, 0);
        rst = 1'b1;
        exp_frames = 0;
        exp_drops  = 0;
        held_mac = '0; held_ip = '0; held_ch = '0; held_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx.o_rdy !== 1'b0 || o_frame_cnt !== 16'd0 || o_drop_cnt !== 16'd0 ||
            o_cmd_data !== 32'h0 || o_arp_sender_mac !== 48'h0) begin
            n_fail++; $display("FAIL reset_mid: rdy=%b frame=%0d drop=%0d data=%h mac=%h, required 0 0 0 0 0",
                               rx.o_rdy, o_frame_cnt, o_drop_cnt, o_cmd_data, o_arp_sender_mac);
        end
        rst = 1'b0;
        send_words(7, 13, 0, 1, 0, 0, 0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (o_frame_cnt !== 16'd0 || o_drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL orphan_tail: frame=%0d drop=%0d, required 0 0", o_frame_cnt, o_drop_cnt);
        end
        send_words(0, 13, 1, 1, 0, 0, 1);
        exp_frames++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || o_frame_cnt !== 16'd1 || o_cmd_data !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL after_reset_frame: pending=%0d frame=%0d data=%h, required 0 1 cafe0001",
                               sb.size(), o_frame_cnt, o_cmd_data);
        end
    endtask

    initial begin
        rx.i_vld  = 1'b0;
        rx.i_sop  = 1'b0;
        rx.i_eop  = 1'b0;
        rx.i_err  = 1'b0;
        rx.i_data = 32'h0;
        test_reset();
        test_arp();
        test_udp_cmd();
        test_short_err();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
